// File: rtl/key_debounce_pkg.sv
// Shared types and helpers for the key debouncer: per-channel state encoding
// and a constant max() used to size the repeat counter.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        KD_IDLE,
        KD_PRESS_WAIT,
        KD_HELD,
        KD_RELEASE_WAIT
    } kd_state_t;

    function automatic int kd_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// Single-channel debouncer: four-state FSM with a stable-sample counter and
// an optional auto-repeat counter. x_i is already polarity-corrected (1 = pressed).
module key_debounce_ch
    import key_debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = 500000,
    parameter int REPEAT_EN     = 1,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_RATE   = 5000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic x_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_o
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam logic [SW-1:0] STABLE_C = SW'(STABLE_CYCLES);

    kd_state_t     state_q, state_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic [SW-1:0] scnt_inc;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          enter_held;

    assign scnt_inc = scnt_q + SW'(1);

    always_comb begin
        state_d    = state_q;
        scnt_d     = scnt_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        enter_held = 1'b0;
        unique case (state_q)
            KD_IDLE: begin
                if (x_i) begin
                    if (STABLE_CYCLES == 1) begin
                        state_d    = KD_HELD;
                        press_d    = 1'b1;
                        enter_held = 1'b1;
                    end else begin
                        state_d = KD_PRESS_WAIT;
                        scnt_d  = SW'(1);
                    end
                end
            end
            KD_PRESS_WAIT: begin
                if (!x_i) begin
                    state_d = KD_IDLE;
                    scnt_d  = '0;
                end else if (scnt_inc == STABLE_C) begin
                    state_d    = KD_HELD;
                    scnt_d     = '0;
                    press_d    = 1'b1;
                    enter_held = 1'b1;
                end else begin
                    scnt_d = scnt_inc;
                end
            end
            KD_HELD: begin
                if (!x_i) begin
                    if (STABLE_CYCLES == 1) begin
                        state_d   = KD_IDLE;
                        release_d = 1'b1;
                    end else begin
                        state_d = KD_RELEASE_WAIT;
                        scnt_d  = SW'(1);
                    end
                end
            end
            KD_RELEASE_WAIT: begin
                // A returning high sample means the drop was a glitch; stay pressed.
                if (x_i) begin
                    state_d = KD_HELD;
                    scnt_d  = '0;
                end else if (scnt_inc == STABLE_C) begin
                    state_d   = KD_IDLE;
                    scnt_d    = '0;
                    release_d = 1'b1;
                end else begin
                    scnt_d = scnt_inc;
                end
            end
            default: begin
                state_d = KD_IDLE;
                scnt_d  = '0;
            end
        endcase
        level_d = (state_d == KD_HELD) || (state_d == KD_RELEASE_WAIT);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= KD_IDLE;
            scnt_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            scnt_q    <= scnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

    generate
        if (REPEAT_EN != 0) begin : g_repeat
            localparam int RCW = $clog2(kd_max(REPEAT_DELAY, REPEAT_RATE) + 1);
            localparam logic [RCW-1:0] DELAY_C = RCW'(REPEAT_DELAY);
            localparam logic [RCW-1:0] RATE_C  = RCW'(REPEAT_RATE);

            logic [RCW-1:0] rcnt_q, rcnt_d;
            logic [RCW-1:0] rcnt_inc;
            logic [RCW-1:0] target;
            logic           first_q, first_d;
            logic           repeat_q, repeat_d;

            assign rcnt_inc = rcnt_q + RCW'(1);
            // The first interval after a press is the longer delay, then the rate.
            assign target   = first_q ? DELAY_C : RATE_C;

            always_comb begin
                rcnt_d   = rcnt_q;
                first_d  = first_q;
                repeat_d = 1'b0;
                if (enter_held) begin
                    rcnt_d  = '0;
                    first_d = 1'b1;
                end else if (level_q) begin
                    if (release_d) begin
                        rcnt_d  = '0;
                        first_d = 1'b1;
                    end else if (rcnt_inc == target) begin
                        repeat_d = 1'b1;
                        rcnt_d   = '0;
                        first_d  = 1'b0;
                    end else begin
                        rcnt_d = rcnt_inc;
                    end
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    rcnt_q   <= '0;
                    first_q  <= 1'b1;
                    repeat_q <= 1'b0;
                end else begin
                    rcnt_q   <= rcnt_d;
                    first_q  <= first_d;
                    repeat_q <= repeat_d;
                end
            end

            assign repeat_o = repeat_q;
        end else begin : g_no_repeat
            assign repeat_o = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/key_debounce.sv
// N-channel key debouncer: applies input polarity and replicates the
// single-channel debouncer across all inputs.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int N             = 4,
    parameter int ACTIVE_LOW    = 1,
    parameter int STABLE_CYCLES = 500000,
    parameter int REPEAT_EN     = 1,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_RATE   = 5000000
) (
    input  logic         Clk_i,
    input  logic         Reset_i,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] level_o,
    output logic [N-1:0] press_o,
    output logic [N-1:0] release_o,
    output logic [N-1:0] repeat_o
);

    localparam logic POL = (ACTIVE_LOW != 0);

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_ch
            logic x;
            assign x = d_i[g] ^ POL;

            key_debounce_ch #(
                .STABLE_CYCLES(STABLE_CYCLES),
                .REPEAT_EN    (REPEAT_EN),
                .REPEAT_DELAY (REPEAT_DELAY),
                .REPEAT_RATE  (REPEAT_RATE)
            ) u_ch (
                .clk_i    (Clk_i),
                .rst_i    (Reset_i),
                .x_i      (x),
                .level_o  (level_o[g]),
                .press_o  (press_o[g]),
                .release_o(release_o[g]),
                .repeat_o (repeat_o[g])
            );
        end
    endgenerate

endmodule
